// File: rtl/rule_filter.sv
// First-stage receive filter: classifies each AXI-Stream packet on its first beat against a
// host-programmable rule table and forwards or drops the whole packet.

module rule_filter #(
  parameter int unsigned AXIS_DATA_WIDTH = 512,
  parameter int unsigned AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8,
  parameter int unsigned NUM_RULES       = 8,
  parameter bit          DEFAULT_ACCEPT  = 1'b1,
  parameter int unsigned CNT_WIDTH       = 32,
  localparam int unsigned IdxW = (NUM_RULES > 1) ? $clog2(NUM_RULES) : 1,
  localparam int unsigned HitW = $clog2(NUM_RULES) + 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [AXIS_KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  input  logic                       s_axis_tlast,
  output logic [AXIS_DATA_WIDTH-1:0] m_axis_tdata,
  output logic [AXIS_KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic                       m_axis_tlast,
  input  logic                       cfg_wr_en,
  input  logic [IdxW-1:0]            cfg_rule,
  input  logic [2:0]                 cfg_word,
  input  logic [31:0]                cfg_wdata,
  output logic [CNT_WIDTH-1:0]       stat_accept_cnt,
  output logic [CNT_WIDTH-1:0]       stat_drop_cnt,
  output logic [HitW-1:0]            stat_last_hit
);

  // Rule table
  logic [NUM_RULES-1:0] en_q, act_q;
  logic [31:0]          dipv_q [NUM_RULES];
  logic [31:0]          dipm_q [NUM_RULES];
  logic [31:0]          sipv_q [NUM_RULES];
  logic [31:0]          sipm_q [NUM_RULES];
  logic [15:0]          etv_q  [NUM_RULES];
  logic [15:0]          etm_q  [NUM_RULES];
  logic [7:0]           prv_q  [NUM_RULES];
  logic [7:0]           prm_q  [NUM_RULES];

  logic cfg_rule_ok;
  assign cfg_rule_ok = 32'(cfg_rule) < NUM_RULES;

  always_ff @(posedge clk) begin
    if (rst) begin
      en_q  <= '0;
      act_q <= '0;
      for (int i = 0; i < NUM_RULES; i++) begin
        dipv_q[i] <= '0;
        dipm_q[i] <= '0;
        sipv_q[i] <= '0;
        sipm_q[i] <= '0;
        etv_q[i]  <= '0;
        etm_q[i]  <= '0;
        prv_q[i]  <= '0;
        prm_q[i]  <= '0;
      end
    end else if (cfg_wr_en && cfg_rule_ok) begin
      case (cfg_word)
        3'd0: begin
          en_q[cfg_rule]  <= cfg_wdata[0];
          act_q[cfg_rule] <= cfg_wdata[1];
        end
        3'd1: dipv_q[cfg_rule] <= cfg_wdata;
        3'd2: dipm_q[cfg_rule] <= cfg_wdata;
        3'd3: sipv_q[cfg_rule] <= cfg_wdata;
        3'd4: sipm_q[cfg_rule] <= cfg_wdata;
        3'd5: begin
          etv_q[cfg_rule] <= cfg_wdata[15:0];
          etm_q[cfg_rule] <= cfg_wdata[31:16];
        end
        3'd6: begin
          prv_q[cfg_rule] <= cfg_wdata[7:0];
          prm_q[cfg_rule] <= cfg_wdata[15:8];
        end
        default: ;
      endcase
    end
  end

  // Stage A (input register) and stage B (output register)
  logic                       a_valid_q, a_last_q, a_first_q, in_first_q, pass_q;
  logic [AXIS_DATA_WIDTH-1:0] a_data_q, m_data_q;
  logic [AXIS_KEEP_WIDTH-1:0] a_keep_q, m_keep_q;
  logic                       m_valid_q, m_last_q;
  logic [CNT_WIDTH-1:0]       acc_q, drop_q;
  logic [HitW-1:0]            last_hit_q;

  // Header fields, network byte order
  logic [15:0] f_et;
  logic [7:0]  f_pr;
  logic [31:0] f_sip, f_dip;
  logic        is_ip;

  assign f_et  = {a_data_q[8*12 +: 8], a_data_q[8*13 +: 8]};
  assign f_pr  = a_data_q[8*23 +: 8];
  assign f_sip = {a_data_q[8*26 +: 8], a_data_q[8*27 +: 8], a_data_q[8*28 +: 8],
                  a_data_q[8*29 +: 8]};
  assign f_dip = {a_data_q[8*30 +: 8], a_data_q[8*31 +: 8], a_data_q[8*32 +: 8],
                  a_data_q[8*33 +: 8]};
  // A truncated or non-IPv4 header only satisfies IP-field rules that wildcard them
  assign is_ip = (f_et == 16'h0800) && a_keep_q[33];

  logic [NUM_RULES-1:0] rule_hit;
  logic                 hit, hit_act;
  logic [IdxW-1:0]      hit_idx;

  always_comb begin
    rule_hit = '0;
    for (int i = 0; i < NUM_RULES; i++) begin
      rule_hit[i] = en_q[i]
          && (((f_et ^ etv_q[i]) & etm_q[i]) == 16'h0)
          && (is_ip ? (((f_dip ^ dipv_q[i]) & dipm_q[i]) == 32'h0) : (dipm_q[i] == 32'h0))
          && (is_ip ? (((f_sip ^ sipv_q[i]) & sipm_q[i]) == 32'h0) : (sipm_q[i] == 32'h0))
          && (is_ip ? (((f_pr ^ prv_q[i]) & prm_q[i]) == 8'h0) : (prm_q[i] == 8'h0));
    end
  end

  always_comb begin
    hit     = 1'b0;
    hit_act = 1'b0;
    hit_idx = '0;
    for (int i = NUM_RULES - 1; i >= 0; i--) begin
      if (rule_hit[i]) begin
        hit     = 1'b1;
        hit_act = act_q[i];
        hit_idx = IdxW'(i);
      end
    end
  end

  logic decision, pass_eff, a_adv, s_ready, s_hs, latch, m_load;
  logic a_valid_d, in_first_d, pass_d, m_valid_d;
  logic [CNT_WIDTH-1:0] acc_d, drop_d;
  logic [HitW-1:0]      last_hit_d;

  always_comb begin
    decision   = hit ? hit_act : DEFAULT_ACCEPT;
    pass_eff   = a_first_q ? decision : pass_q;
    // Dropped beats never wait on the output side
    a_adv      = a_valid_q && (!pass_eff || !m_valid_q || m_axis_tready);
    s_ready    = !a_valid_q || a_adv;
    s_hs       = s_axis_tvalid && s_ready;
    a_valid_d  = s_hs || (a_valid_q && !a_adv);
    in_first_d = s_hs ? s_axis_tlast : in_first_q;
    latch      = a_adv && a_first_q;
    pass_d     = latch ? decision : pass_q;
    acc_d      = (latch && decision) ? acc_q + CNT_WIDTH'(1) : acc_q;
    drop_d     = (latch && !decision) ? drop_q + CNT_WIDTH'(1) : drop_q;
    last_hit_d = latch ? ((HitW'(hit) << (HitW - 1)) | HitW'(hit_idx)) : last_hit_q;
    m_load     = a_adv && pass_eff;
    m_valid_d  = m_load || (m_valid_q && !m_axis_tready);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_valid_q  <= 1'b0;
      a_last_q   <= 1'b0;
      a_first_q  <= 1'b0;
      in_first_q <= 1'b1;
      pass_q     <= 1'b0;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      m_keep_q   <= '0;
      m_last_q   <= 1'b0;
      acc_q      <= '0;
      drop_q     <= '0;
      last_hit_q <= '0;
    end else begin
      a_valid_q  <= a_valid_d;
      in_first_q <= in_first_d;
      pass_q     <= pass_d;
      m_valid_q  <= m_valid_d;
      acc_q      <= acc_d;
      drop_q     <= drop_d;
      last_hit_q <= last_hit_d;
      if (s_hs) begin
        a_last_q  <= s_axis_tlast;
        a_first_q <= in_first_q;
      end
      if (m_load) begin
        m_data_q <= a_data_q;
        m_keep_q <= a_keep_q;
        m_last_q <= a_last_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (s_hs) begin
      a_data_q <= s_axis_tdata;
      a_keep_q <= s_axis_tkeep;
    end
  end

  assign s_axis_tready   = s_ready;
  assign m_axis_tdata    = m_data_q;
  assign m_axis_tkeep    = m_keep_q;
  assign m_axis_tvalid   = m_valid_q;
  assign m_axis_tlast    = m_last_q;
  assign stat_accept_cnt = acc_q;
  assign stat_drop_cnt   = drop_q;
  assign stat_last_hit   = last_hit_q;

endmodule

// File: doc/rule_filter.md
Name: rule_filter

Overview:
- Parametrised successor of the first-stage receive filter.
- Classifies each incoming AXI-Stream packet against a host-programmable table of NUM_RULES match rules on its Ethernet/IPv4 header, then forwards or drops the whole packet.
- Sits first on the receive path, ahead of the app datapath.
- Adds over the previous generation: full tready backpressure, a per-packet decision held until tlast, a rule table with masks and priority, and statistics counters.

Parameters:
AXIS_DATA_WIDTH, 512, tdata width; must be >=272 and a multiple of 8 (the whole header fits in the first beat)
AXIS_KEEP_WIDTH, AXIS_DATA_WIDTH/8, tkeep width
NUM_RULES, 8, rule table entries (1..32)
DEFAULT_ACCEPT, 1, action when no enabled rule hits (1 = forward, 0 = drop)
CNT_WIDTH, 32, statistics counter width

Ports:
clk  in  1  single clock
rst  in  1  synchronous active-high reset
s_axis_tdata  in  AXIS_DATA_WIDTH  input beat; byte 0 in [7:0]
s_axis_tkeep  in  AXIS_KEEP_WIDTH  input byte enables
s_axis_tvalid  in  1  input valid
s_axis_tready  out  1  input ready
s_axis_tlast  in  1  last beat of packet
m_axis_tdata  out  AXIS_DATA_WIDTH  output beat
m_axis_tkeep  out  AXIS_KEEP_WIDTH  output byte enables
m_axis_tvalid  out  1  output valid
m_axis_tready  in  1  output ready
m_axis_tlast  out  1  output last
cfg_wr_en  in  1  rule table write strobe
cfg_rule  in  $clog2(NUM_RULES) (min 1)  rule index
cfg_word  in  3  field select
cfg_wdata  in  32  write data
stat_accept_cnt  out  CNT_WIDTH  forwarded packets
stat_drop_cnt  out  CNT_WIDTH  dropped packets
stat_last_hit  out  $clog2(NUM_RULES)+1  {hit, index} of the most recent decision

Behaviour:
- Config words per rule:
  - 0: {action[1], enable[0]}
  - 1: dst IP value; 2: dst IP mask
  - 3: src IP value; 4: src IP mask
  - 5: {ethertype mask[31:16], ethertype value[15:0]}
  - 6: {proto mask[15:8], proto value[7:0]}
  - 7: reserved, writes ignored.
- Writes take effect the next cycle. A decision evaluated in the same cycle as a write uses the old value.
- Field extraction from the first beat, network byte order:
  - EtherType = bytes 12,13
  - proto = byte 23
  - src IP = bytes 26..29
  - dst IP = bytes 30..33
- Field match: (field & mask) == (value & mask).
- If EtherType != 0x0800, or tkeep[33]==0: each IP field matches only if its mask is 0.
- Rule hits when enable=1 and all fields match. Lowest index hit wins. Action = hit ? action bit : DEFAULT_ACCEPT.
- Pipeline:
  - Stage A is an input register. s_axis_tready = !a_valid || a_adv.
  - Stage B is the output register. a_adv = a_valid && (!pass || !m_axis_tvalid || m_axis_tready).
- Decision:
  - Computed from stage A when it holds the first beat (first-beat flag set after reset and after every accepted tlast).
  - Latched in `pass` for all following beats through tlast.
- Dropped beats are consumed at one per cycle and never reach m_axis.
- Latency: 2 cycles from s_axis handshake to m_axis_tvalid with no backpressure. Sustained throughput is one beat per cycle.
- While m_axis_tvalid=1 and tready=0, m_axis data/keep/last are held stable.
- Counters increment once per packet, in the cycle the decision latches. They wrap at 2^CNT_WIDTH.
- Single-beat packet (first beat with tlast): decision and termination happen on the same beat.
- Reset (any time, including mid-packet):
  - All outputs 0, counters 0, stat_last_hit 0.
  - Pipeline emptied; first-beat flag set.
  - All rules 0 (disabled, masks 0).
  - A partial packet is discarded.

Test Plan:
- Reset, no rules, DEFAULT_ACCEPT=1; 3-beat IPv4 packet -> 3 identical beats on m_axis, tlast on beat 3, stat_accept_cnt=1, stat_last_hit=0.
- Rule 2: enable, action=0, dst IP 10.0.0.5 mask FFFFFFFF; send dst 10.0.0.5 then dst 10.0.0.6 -> first packet dropped with tready held high, second forwarded; drop_cnt=1, accept_cnt=1, stat_last_hit after the first packet = {1,2}.
- Rules 1 (drop) and 3 (accept) both match proto 17 -> rule 1 wins, packet dropped.
- ARP frame (EtherType 0x0806) vs rule with proto mask FF -> no hit. A rule with only EtherType 0x0806/FFFF and action=1 -> hit, forwarded.
- Random m_axis_tready 50% over 20 back-to-back packets -> no beat lost or duplicated, data stable while stalled, counts exact.
- Reset asserted on beat 2 of a 4-beat packet -> outputs 0 next cycle. A following packet is decided fresh with rules disabled.
